// File: rtl/mvau_defn.sv
// Shared width definitions for the matrix-vector unit, so the SIMD and PE
// stages always agree on lane and accumulator widths.
package mvau_defn;

  localparam int DEF_SIMD   = 4;
  localparam int DEF_SF     = 3;
  localparam int DEF_TDSTI  = 16;
  localparam int DEF_OP_SGN = 1;

  // Sum of SIMD lanes over SF folds can never exceed this many bits.
  function automatic int to_width(input int tdsti, input int simd, input int sf);
    return tdsti + $clog2(simd) + $clog2(sf);
  endfunction

  // Fold counter width; kept at least one bit so SF=1 still has a register.
  function automatic int cnt_width(input int sf);
    return (sf > 1) ? $clog2(sf) : 1;
  endfunction

endpackage

// File: rtl/mvu_pe_acc_if.sv
// Product stream into, and dot-product results out of, one PE accumulator.
interface mvu_pe_acc_if
  import mvau_defn::*;
#(
    parameter int SIMD  = DEF_SIMD,
    parameter int TDstI = DEF_TDSTI,
    parameter int TO    = to_width(DEF_TDSTI, DEF_SIMD, DEF_SF)
);

    logic                    in_v;
    logic [SIMD*TDstI-1:0]   in_simd;
    logic                    out_v;
    logic [TO-1:0]           out;

    modport master (output in_v, output in_simd, input out_v, input out);
    modport slave  (input in_v, input in_simd, output out_v, output out);

endinterface

// File: rtl/mvu_pe_adders.sv
// Stage 1: extends every SIMD product lane to the accumulator width and
// registers their sum together with its valid.
module mvu_pe_adders
  import mvau_defn::*;
#(
    parameter int SIMD   = DEF_SIMD,
    parameter int TDstI  = DEF_TDSTI,
    parameter int OP_SGN = DEF_OP_SGN,
    parameter int TO     = to_width(DEF_TDSTI, DEF_SIMD, DEF_SF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_v,
    input  logic [SIMD*TDstI-1:0] in_simd,
    output logic [TO-1:0]         sum_r,
    output logic                  sum_v
);

    logic [TO-1:0]    sum_c;
    logic [TDstI-1:0] lane;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        sum_c = '0;
        lane  = '0;
        for (int i = 0; i < SIMD; i++) begin
            lane = in_simd[i*TDstI +: TDstI];
            if (OP_SGN != 0) sum_c = sum_c + TO'($signed(lane));
            else             sum_c = sum_c + TO'(lane);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_r <= '0;
            sum_v <= 1'b0;
        end else begin
            sum_r <= sum_c;
            sum_v <= in_v;
        end
    end

endmodule

// File: rtl/mvu_pe_acc.sv
// PE accumulator: folds SF lane-sum beats into one dot-product and presents
// it with a single-cycle out_v pulse two cycles after the last input beat.
module mvu_pe_acc
  import mvau_defn::*;
#(
    parameter int SIMD   = DEF_SIMD,
    parameter int SF     = DEF_SF,
    parameter int TDstI  = DEF_TDSTI,
    parameter int OP_SGN = DEF_OP_SGN,
    parameter int TO     = to_width(TDstI, SIMD, SF)
) (
    input  logic         clk,
    input  logic         rst_n,
    mvu_pe_acc_if.slave  bus
);

    localparam int CNT_W = cnt_width(SF);

    logic [TO-1:0]    sum_r;
    logic             sum_v;
    logic [CNT_W-1:0] sf_cnt;
    logic [TO-1:0]    acc;
    logic             fin;

    mvu_pe_adders #(
        .SIMD   (SIMD),
        .TDstI  (TDstI),
        .OP_SGN (OP_SGN),
        .TO     (TO)
    ) u_adders (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_v    (bus.in_v),
        .in_simd (bus.in_simd),
        .sum_r   (sum_r),
        .sum_v   (sum_v)
    );

    // fin marks that acc now holds a completed fold; it is published next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sf_cnt    <= '0;
            acc       <= '0;
            fin       <= 1'b0;
            bus.out   <= '0;
            bus.out_v <= 1'b0;
        end else begin
            fin       <= 1'b0;
            bus.out_v <= fin;
            if (fin) bus.out <= acc;
            if (sum_v) begin
                acc <= (sf_cnt == '0) ? sum_r : acc + sum_r;
                if (sf_cnt == CNT_W'(SF - 1)) begin
                    sf_cnt <= '0;
                    fin    <= 1'b1;
                end else begin
                    sf_cnt <= sf_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mvu_pe_acc.sv
// Directed bench for mvu_pe_acc: an SF=3 instance for the fold scenarios and
// an SF=1 instance for the single-beat case, both SIMD=4, 8-bit signed lanes.
module tb_mvu_pe_acc;

    localparam int SIMD  = 4;
    localparam int TDSTI = 8;
    localparam int TO3   = 12;
    localparam int TO1   = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   pulses3 = 0;
    int   pulses1 = 0;
    int   p0;

    always #5 clk = ~clk;

    mvu_pe_acc_if #(.SIMD(SIMD), .TDstI(TDSTI), .TO(TO3)) b3 ();
    mvu_pe_acc_if #(.SIMD(SIMD), .TDstI(TDSTI), .TO(TO1)) b1 ();

    mvu_pe_acc #(.SIMD(SIMD), .SF(3), .TDstI(TDSTI), .OP_SGN(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(b3.slave));
    mvu_pe_acc #(.SIMD(SIMD), .SF(1), .TDstI(TDSTI), .OP_SGN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave));

    always @(negedge clk) begin
        if (b3.out_v === 1'b1) pulses3++;
        if (b1.out_v === 1'b1) pulses1++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lanes(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    // One accepted beat on the chosen instance (sel=1 -> SF=1 instance).
    task automatic beat(input bit sel, input logic [31:0] v);
        if (sel) begin
            b1.in_v    = 1'b1;
            b1.in_simd = v;
        end else begin
            b3.in_v    = 1'b1;
            b3.in_simd = v;
        end
        step();
        b3.in_v = 1'b0;
        b1.in_v = 1'b0;
    endtask

    initial begin
        b3.in_v = 1'b0; b3.in_simd = '0;
        b1.in_v = 1'b0; b1.in_simd = '0;

        // Reset state
        step(); step();
        check("rst_out_v3", 16'(b3.out_v), 16'd0);
        check("rst_out3",   16'(b3.out),   16'd0);
        check("rst_out_v1", 16'(b1.out_v), 16'd0);
        check("rst_out1",   16'(b1.out),   16'd0);
        rst_n = 1'b1;
        step();

        // Scenario 1: three beats of all-ones lanes
        p0 = pulses3;
        beat(0, lanes(1, 1, 1, 1));
        beat(0, lanes(1, 1, 1, 1));
        beat(0, lanes(1, 1, 1, 1));
        check("s1_early_t",  16'(b3.out_v), 16'd0);
        step();
        check("s1_early_t1", 16'(b3.out_v), 16'd0);
        step();
        check("s1_out_v", 16'(b3.out_v), 16'd1);
        check("s1_out",   16'(b3.out),   16'd12);
        step();
        check("s1_pulse_end", 16'(b3.out_v), 16'd0);
        check("s1_out_hold",  16'(b3.out),   16'd12);
        step();
        check("s1_pulses", 16'(pulses3 - p0), 16'd1);

        // Scenario 2: most-negative lanes, result -1536 in 12 bits
        beat(0, lanes(-128, -128, -128, -128));
        beat(0, lanes(-128, -128, -128, -128));
        beat(0, lanes(-128, -128, -128, -128));
        step(); step();
        check("s2_out_v", 16'(b3.out_v), 16'd1);
        check("s2_out",   16'(b3.out),   16'h0A00);
        step(); step();

        // Scenario 3: bubbles between beats 5, 6, 7
        p0 = pulses3;
        beat(0, lanes(5, 0, 0, 0));
        step();
        beat(0, lanes(2, 4, 0, 0));
        step(); step();
        beat(0, lanes(-1, 3, 2, 3));
        step(); step();
        check("s3_out_v", 16'(b3.out_v), 16'd1);
        check("s3_out",   16'(b3.out),   16'd18);
        step(); step();
        check("s3_pulses", 16'(pulses3 - p0), 16'd1);

        // Scenario 4: six back-to-back beats, sums 1..6
        p0 = pulses3;
        beat(0, lanes(1, 0, 0, 0));
        beat(0, lanes(0, 2, 0, 0));
        beat(0, lanes(0, 0, 3, 0));
        beat(0, lanes(0, 0, 0, 4));
        beat(0, lanes(2, 3, 0, 0));
        check("s4_first_v", 16'(b3.out_v), 16'd1);
        check("s4_first",   16'(b3.out),   16'd6);
        beat(0, lanes(1, 1, 2, 2));
        check("s4_gap_v",   16'(b3.out_v), 16'd0);
        step(); step();
        check("s4_second_v", 16'(b3.out_v), 16'd1);
        check("s4_second",   16'(b3.out),   16'd15);
        step(); step();
        check("s4_pulses", 16'(pulses3 - p0), 16'd2);

        // Scenario 5: reset aborts a partial fold
        p0 = pulses3;
        beat(0, lanes(3, 0, 0, 0));
        beat(0, lanes(3, 0, 0, 0));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("s5_rst_out_v", 16'(b3.out_v), 16'd0);
        check("s5_rst_out",   16'(b3.out),   16'd0);
        beat(0, lanes(1, 1, 0, 0));
        beat(0, lanes(1, 1, 0, 0));
        beat(0, lanes(1, 1, 0, 0));
        step(); step();
        check("s5_out_v", 16'(b3.out_v), 16'd1);
        check("s5_out",   16'(b3.out),   16'd6);
        step(); step();
        check("s5_pulses", 16'(pulses3 - p0), 16'd1);

        // Scenario 6: SF=1 instance, every beat is a result
        p0 = pulses1;
        beat(1, lanes(1, 2, 0, 0));
        beat(1, lanes(1, 1, 1, 1));
        step();
        check("s6_first_v", 16'(b1.out_v), 16'd1);
        check("s6_first",   16'(b1.out),   16'd3);
        step();
        check("s6_second_v", 16'(b1.out_v), 16'd1);
        check("s6_second",   16'(b1.out),   16'd4);
        step();
        check("s6_end_v",  16'(b1.out_v), 16'd0);
        check("s6_hold",   16'(b1.out),   16'd4);
        step();
        check("s6_pulses", 16'(pulses1 - p0), 16'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mvu_pe_acc.md
MVU_PE_ACC -- requirements
Module: mvu_pe_acc

Interface
REQ-001 The block SHALL take parameter SIMD, default 4: number of SIMD product lanes per beat.
REQ-002 The block SHALL take parameter SF, default 3: synapse-fold beats per output (SF >= 1).
REQ-003 The block SHALL take parameter TDstI, default 16: width of one SIMD product lane.
REQ-004 The block SHALL take parameter OP_SGN, default 1: 1 means signed products, 0 means unsigned.
REQ-005 The block SHALL take derived parameter TO = TDstI + $clog2(SIMD) + $clog2(SF): accumulator and output width.
REQ-006 The block SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-008 The block SHALL have port in_v, input, 1 bit: the products on in_simd are valid this cycle.
REQ-009 The block SHALL have port in_simd, input, SIMD*TDstI bits: packed registered SIMD products; lane i occupies bits [i*TDstI +: TDstI].
REQ-010 The block SHALL have port out_v, output, 1 bit: one-cycle pulse marking a completed dot-product.
REQ-011 The block SHALL have port out, output, TO bits: accumulated dot-product result.

Function
REQ-012 Stage 1 SHALL sign-extend (OP_SGN=1) or zero-extend (OP_SGN=0) every lane to TO bits.
REQ-013 Stage 1 SHALL sum all extended lanes and register the sum as sum_r, with a registered valid sum_v = in_v; latency is 1 cycle.
REQ-014 Stage 2 SHALL keep a fold counter sf_cnt, range 0..SF-1, that advances only on cycles where sum_v=1.
REQ-015 On a sum_v beat with sf_cnt==0, the accumulator SHALL load sum_r; on a sum_v beat with sf_cnt>0, it SHALL load acc+sum_r.
REQ-016 On a sum_v beat with sf_cnt==SF-1, sf_cnt SHALL wrap to 0 and the next cycle SHALL present out = the final accumulator value with out_v=1.
REQ-017 Total latency SHALL be 2 cycles: last in_v beat at edge t gives out_v=1 after edge t+2.
REQ-018 Cycles with in_v=0 SHALL be bubbles: sf_cnt, the accumulator and out SHALL hold, and no beat is counted.
REQ-019 out_v SHALL be high for exactly one cycle per SF accepted beats; out SHALL hold its last value while out_v=0.
REQ-020 With SF=1, every valid beat SHALL produce an output; the accumulator SHALL always load and never add.
REQ-021 Back-to-back folds with no bubble SHALL be supported: a beat with sf_cnt==0 immediately after a wrap SHALL start the new sum without loss.
REQ-022 Arithmetic SHALL be exact within TO bits, with no saturation; TO is sized so overflow cannot occur for in-range operands.

Reset
REQ-023 While rst_n=0 at a clock edge, sum_r, sum_v, sf_cnt, the accumulator, out and out_v SHALL all be cleared to 0.
REQ-024 Reset asserted mid-fold SHALL discard the partial sum and produce no out_v; the first valid beat after reset SHALL be treated as sf_cnt==0.

Structure
REQ-025 SIMD, SF, TDstI, OP_SGN and the TO derivation SHALL come from the shared mvau_defn package, so SIMD and PE stages agree on widths.
REQ-026 The lane-sum stage SHALL be a sub-module named mvu_pe_adders; accumulation and fold control SHALL stay in mvu_pe_acc.

Verification (SIMD=4, SF=3, TDstI=8, OP_SGN=1)
REQ-027 Scenario 1: three consecutive beats with all lanes =1 -> a single out_v pulse 2 cycles after the third beat, out=12.
REQ-028 Scenario 2: lanes {-128,-128,-128,-128} for 3 beats -> out=-1536, correctly sign-extended in TO=12 bits.
REQ-029 Scenario 3: beats of sum 5, then a bubble, then 6, then two bubbles, then 7 -> one out_v pulse only, out=18.
REQ-030 Scenario 4: six back-to-back beats with sums 1..6 -> two out_v pulses 3 cycles apart, out=6 then out=15.
REQ-031 Scenario 5: two beats accepted, rst_n low 1 cycle, then three beats of sum 2 -> no pulse from the aborted fold, then out=6.
REQ-032 Scenario 6: SF=1 with beats 3, 4 -> out_v on consecutive cycles with out=3, then out=4.
